// File: rtl/pmod_jstk_responder.sv
// PmodJSTK joystick emulator: SPI mode 0 slave that answers a 5-byte frame
// with X, Y and button data and captures the master's LED command byte.
module pmod_jstk_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_BYTES   = 5
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    output logic [1:0] led_cmd,
    output logic       xfer_done,
    output logic       frame_err
);

    localparam logic [5:0] NUM_BITS = 6'(NUM_BYTES * 8);
    // One past a full frame marks an over-length transfer.
    localparam logic [5:0] OVER_CNT = NUM_BITS + 6'd1;

    typedef enum logic [1:0] {
        StWaitIdle,
        StIdle,
        StShift
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_dly;
    logic                   sclk_dly;

    logic [38:0] tx_sr;   // bits still to be sent after the one on MISO
    logic [39:0] rx_sr;
    logic [5:0]  bit_cnt;
    logic [39:0] snap;

    logic ss_s, sclk_s, mosi_s;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign ss_fall   = ss_dly & ~ss_s;
    assign ss_rise   = ~ss_dly & ss_s;
    assign sclk_rise = ~sclk_dly & sclk_s;
    assign sclk_fall = sclk_dly & ~sclk_s;

    // Outgoing frame, MSB of byte 0 first.
    assign snap = {x_pos[7:0], 6'b0, x_pos[9:8], y_pos[7:0], 6'b0, y_pos[9:8], 5'b0, btn};

    // Input synchronizers plus one delay flop each for edge detection.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ss_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_dly    <= 1'b0;
            sclk_dly  <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_dly    <= ss_s;
            sclk_dly  <= sclk_s;
        end
    end

    // Frame FSM with registered MISO, LED command and status pulses.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= StWaitIdle;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            MISO      <= 1'b0;
            led_cmd   <= 2'b00;
            xfer_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                // Ignore any frame already in flight when reset released.
                StWaitIdle: begin
                    MISO <= 1'b0;
                    if (ss_s) begin
                        state <= StIdle;
                    end
                end
                StIdle: begin
                    MISO <= 1'b0;
                    if (ss_fall) begin
                        tx_sr   <= snap[38:0];
                        MISO    <= snap[39];
                        bit_cnt <= '0;
                        rx_sr   <= '0;
                        state   <= StShift;
                    end
                end
                StShift: begin
                    // SS rise takes priority over a coincident SCLK edge.
                    if (ss_rise) begin
                        state <= StIdle;
                        MISO  <= 1'b0;
                        if (bit_cnt == NUM_BITS) begin
                            xfer_done <= 1'b1;
                            if (rx_sr[39:34] == 6'b100000) begin
                                led_cmd <= rx_sr[33:32];
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        if (bit_cnt < NUM_BITS) begin
                            rx_sr <= {rx_sr[38:0], mosi_s};
                        end
                        if (bit_cnt < OVER_CNT) begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt < NUM_BITS) begin
                            MISO  <= tx_sr[38];
                            tx_sr <= {tx_sr[37:0], 1'b0};
                        end else begin
                            MISO <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= StWaitIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmod_jstk_responder.sv
// Directed bench for pmod_jstk_responder: drives SPI mode 0 frames and
// compares MISO bytes, LED command and status pulses against fixed values.
module tb_pmod_jstk_responder;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       SS = 1'b1;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [9:0] x_pos = 10'h2A5;
    logic [9:0] y_pos = 10'h13C;
    logic [2:0] btn = 3'b101;
    logic [1:0] led_cmd;
    logic       xfer_done;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    pmod_jstk_responder #(
        .SYNC_STAGES(2),
        .NUM_BYTES  (5)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .SS       (SS),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .x_pos    (x_pos),
        .y_pos    (y_pos),
        .btn      (btn),
        .led_cmd  (led_cmd),
        .xfer_done(xfer_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count clk cycles each status pulse is high.
    always @(negedge clk) begin
        if (xfer_done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One SPI frame; SCLK half period is 5 clk. chg_at/rst_at < 0 disables.
    task automatic spi_frame(input logic [39:0] tx, input int nbits, input int chg_at,
                             input logic [9:0] chg_x, input int rst_at,
                             output logic [47:0] rx);
        logic [39:0] sh;
        sh = tx;
        rx = '0;
        @(negedge clk);
        SS   = 1'b0;
        MOSI = sh[39];
        repeat (5) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                clr_n = 1'b0;
                #1;
                check("rst_miso", 64'(MISO), 64'd0);
                check("rst_led", 64'(led_cmd), 64'd0);
                @(negedge clk);
                clr_n = 1'b1;
            end
            rx[47-i] = MISO;
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
            sh   = sh << 1;
            MOSI = sh[39];
            if (i == chg_at) x_pos = chg_x;
            repeat (5) @(negedge clk);
        end
        SS = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    logic [47:0] rx;
    int d0, e0;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", 64'({MISO, led_cmd, xfer_done, frame_err}), 64'd0);
        clr_n = 1'b1;
        repeat (10) @(negedge clk);

        // Full frame with LED command 0x83.
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(40'h83_0000_0000, 40, -1, 10'h0, -1, rx);
        check("f1_miso", 64'(rx[47:8]), 64'hA5_02_3C_01_05);
        check("f1_led", 64'(led_cmd), 64'd3);
        check("f1_done", 64'(done_cnt - d0), 64'd1);
        check("f1_err", 64'(err_cnt - e0), 64'd0);

        // Invalid command byte: LED holds.
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(40'h40_0000_0000, 40, -1, 10'h0, -1, rx);
        check("f2_miso", 64'(rx[47:8]), 64'hA5_02_3C_01_05);
        check("f2_led", 64'(led_cmd), 64'd3);
        check("f2_done", 64'(done_cnt - d0), 64'd1);
        check("f2_err", 64'(err_cnt - e0), 64'd0);

        // Short frame of 16 bits.
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(40'h81_0000_0000, 16, -1, 10'h0, -1, rx);
        check("f3_miso", 64'(rx[47:32]), 64'hA502);
        check("f3_led", 64'(led_cmd), 64'd3);
        check("f3_done", 64'(done_cnt - d0), 64'd0);
        check("f3_err", 64'(err_cnt - e0), 64'd1);

        // Full frame 0x81.
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(40'h81_0000_0000, 40, -1, 10'h0, -1, rx);
        check("f4_led", 64'(led_cmd), 64'd1);
        check("f4_done", 64'(done_cnt - d0), 64'd1);
        check("f4_err", 64'(err_cnt - e0), 64'd0);

        // Over-length frame of 48 bits.
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(40'h82_0000_0000, 48, -1, 10'h0, -1, rx);
        check("f5_miso", 64'(rx[47:8]), 64'hA5_02_3C_01_05);
        check("f5_tail", 64'(rx[7:0]), 64'd0);
        check("f5_led", 64'(led_cmd), 64'd1);
        check("f5_done", 64'(done_cnt - d0), 64'd0);
        check("f5_err", 64'(err_cnt - e0), 64'd1);

        // x_pos changes after bit 3: this frame keeps the snapshot.
        d0 = done_cnt;
        spi_frame(40'h00_0000_0000, 40, 3, 10'h0FF, -1, rx);
        check("f6_miso", 64'(rx[47:8]), 64'hA5_02_3C_01_05);
        check("f6_done", 64'(done_cnt - d0), 64'd1);
        check("f6_led", 64'(led_cmd), 64'd1);
        spi_frame(40'h00_0000_0000, 40, -1, 10'h0, -1, rx);
        check("f7_miso", 64'(rx[47:8]), 64'hFF_00_3C_01_05);

        // Reset at bit 20 with SS held low.
        d0 = done_cnt; e0 = err_cnt;
        spi_frame(40'h81_0000_0000, 40, -1, 10'h0, 20, rx);
        check("f8_head", 64'(rx[47:28]), 64'hFF003);
        check("f8_tail", 64'(rx[27:8]), 64'd0);
        check("f8_done", 64'(done_cnt - d0), 64'd0);
        check("f8_err", 64'(err_cnt - e0), 64'd0);
        check("f8_led", 64'(led_cmd), 64'd0);

        d0 = done_cnt; e0 = err_cnt;
        spi_frame(40'h82_0000_0000, 40, -1, 10'h0, -1, rx);
        check("f9_miso", 64'(rx[47:8]), 64'hFF_00_3C_01_05);
        check("f9_led", 64'(led_cmd), 64'd2);
        check("f9_done", 64'(done_cnt - d0), 64'd1);
        check("f9_err", 64'(err_cnt - e0), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pmod_jstk_responder.md
Name: pmod_jstk_responder

Overview:
- SPI slave that emulates the PmodJSTK joystick module, the target end of the joystick SPI link.
- Answers a 5-byte master transaction with X, Y and button data supplied on its inputs.
- Captures the master's LED command byte.
- Used as an on-chip stand-in for the physical Pmod during board bring-up and as a bench model for the joystick master.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizers on SS, SCLK and MOSI (legal 2..3)
NUM_BYTES, 5, bytes per frame; fixed at 5, not to be overridden

Ports:
clk  input  1  system clock, 100 MHz
clr_n  input  1  asynchronous active-low reset
SS  input  1  slave select from master, active low
SCLK  input  1  serial clock from master, mode 0, idle low
MOSI  input  1  master out, slave in
MISO  output  1  slave out, master in
x_pos  input  10  joystick X value to report
y_pos  input  10  joystick Y value to report
btn  input  3  {btn2, btn1, jstk_btn}, 1 = pressed
led_cmd  output  2  last valid LED command {LD2, LD1}
xfer_done  output  1  one-clk pulse after a complete 40-bit frame
frame_err  output  1  one-clk pulse after an aborted or over-length frame

Behaviour:
- Reset (clr_n low, async): all outputs 0 (MISO, led_cmd, xfer_done, frame_err); shift registers 0; bit_cnt 0; state WAIT_IDLE.
- Synchronization and edge detection:
  - SS, SCLK and MOSI each pass through SYNC_STAGES flops.
  - Edges are detected from the last sync stage against one extra delay flop.
  - Requires SCLK period >= 8 clk periods.
- Protocol: SPI mode 0, MSB first. Master samples MISO on SCLK rise; slave shifts MISO on SCLK fall and samples MOSI on SCLK rise.
- Transmit frame, in order:
  - x_pos[7:0]
  - {6'b0, x_pos[9:8]}
  - y_pos[7:0]
  - {6'b0, y_pos[9:8]}
  - {5'b0, btn}
- States:
  - WAIT_IDLE: entered from reset. Go to IDLE once synced SS = 1. Prevents responding to a frame that was in progress when reset released.
  - IDLE:
    - MISO = 0.
    - On synced SS fall: snapshot x_pos/y_pos/btn into a 40-bit tx register, drive MISO = tx[39] on the next clk, clear bit_cnt and rx register, go to SHIFT.
  - SHIFT:
    - On SCLK rise: if bit_cnt < 40, shift synced MOSI into rx; bit_cnt saturates at 41 (41 marks over-length).
    - On SCLK fall: if bit_cnt < 40, MISO = next tx bit; else MISO = 0.
    - On synced SS rise: go to IDLE and evaluate:
      - bit_cnt == 40: xfer_done = 1 for one clk. If rx byte0[7:2] == 6'b100000, led_cmd <= rx byte0[1:0]; otherwise led_cmd holds.
      - any other count (0..39, or 41): frame_err = 1 for one clk; led_cmd holds; no xfer_done.
- Latency:
  - MISO first bit valid within SYNC_STAGES+2 clk of the raw SS fall.
  - Subsequent bits valid within SYNC_STAGES+2 clk of the raw SCLK fall.
  - xfer_done/frame_err within SYNC_STAGES+2 clk of the raw SS rise.
- Snapshot: input changes during SHIFT do not affect the current frame; new values are used from the next SS fall.
- Simultaneous SCLK edge and SS rise in the same clk: SS rise wins; the edge is ignored.
- Back-to-back frames: SS high for >= 2 clk after sync is sufficient to start a new frame.
- Reset mid-frame: outputs clear immediately. Must see SS high before the next frame; no xfer_done/frame_err is generated for the interrupted frame.

Test Plan:
- x_pos=0x2A5, y_pos=0x13C, btn=3'b101; master sends 0x83,00,00,00,00 -> MISO bytes A5,02,3C,01,05; led_cmd=2'b11; one xfer_done pulse; frame_err stays 0.
- Master sends 0x40 as byte 0, full 40 bits -> xfer_done pulses; led_cmd keeps prior value 2'b11.
- SS raised after 16 SCLK cycles -> frame_err one-clk pulse, no xfer_done, led_cmd unchanged. Next full frame with 0x81 -> led_cmd=2'b01.
- 48 SCLK cycles in one frame -> MISO 0 for bits 41-48, frame_err pulse, led_cmd unchanged.
- x_pos changed 0x2A5->0x0FF after bit 3 of a frame -> that frame still returns A5,02; following frame returns FF,00.
- clr_n pulsed low at bit 20 with SS held low -> MISO=0 immediately; remaining SCLKs produce no output or pulses. After SS high then a full 0x82 frame -> led_cmd=2'b10, xfer_done pulse.
